// File: rtl/unified_mem_pkg.sv
// unified_mem_pkg: shared constants for the unified line memory.
// Holds the line width, default line-address width, FSM state encoding
// and the latency down-counter width used by unified_mem.
package unified_mem_pkg;

    localparam int LINE_W         = 64;
    localparam int ADDR_W_DEFAULT = 14;

    // Down-counter wide enough for the largest legal LATENCY (15).
    localparam int CNT_W = 4;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Both re and we high counts as a write, so the write strobe alone decides the operation.
    function automatic logic op_is_write(input logic req_we);
        return req_we;
    endfunction

endpackage

// File: rtl/unified_mem_array.sv
// unified_mem_array: 2**ADDR_W x LINE_W storage with one synchronous write
// port and one synchronous, enabled read port. The read register clears on
// rst; the array itself is never reset.
module unified_mem_array
    import unified_mem_pkg::*;
#(
    parameter int    ADDR_W    = ADDR_W_DEFAULT,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**ADDR_W];
    logic [LINE_W-1:0] rdata_d, rdata_q;

    // Write port: commit a line when the controller strobes wr_en.
    // NOTE: the storage array has no reset; clearing it would turn a RAM into a bank of flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data only changes on a read, so writes leave it untouched.
    always_comb begin
        rdata_d = rd_en ? mem[raddr] : rdata_q;
    end

    // Read register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/unified_mem.sv
// unified_mem: fixed-latency line memory controller (IDLE -> BUSY -> DONE).
// A request is latched in IDLE, the access is performed LATENCY cycles later
// and rdy pulses for one cycle. Optional feature: define
// UNIFIED_MEM_STALL_CNT_EN to add the saturating stall_cnt busy-cycle counter.
module unified_mem
    import unified_mem_pkg::*;
#(
    parameter int    ADDR_W    = ADDR_W_DEFAULT,
    parameter int    LATENCY   = 4,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata,
    output logic              rdy
`ifdef UNIFIED_MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [1:0]        state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [LINE_W-1:0] wdata_d, wdata_q;
    logic              op_wr_d, op_wr_q;

    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] acc_addr;
    logic [LINE_W-1:0] acc_wdata;

    // Next-state, request latching and access strobes.
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (re || we) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_wr_d = op_is_write(we);
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: access on the acceptance edge itself.
                        state_d   = ST_DONE;
                        mem_we    = op_is_write(we);
                        mem_re    = !op_is_write(we);
                        acc_addr  = addr;
                        acc_wdata = wdata;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    // Counter reaches zero on this edge: perform the latched access.
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    mem_we  = op_wr_q;
                    mem_re  = !op_wr_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset aborts any access that would land on this edge.
        if (rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    // Control state: synchronous reset to IDLE with a cleared counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
        end
    end

    // Latched request datapath; only meaningful once a request is accepted.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign rdy = (state_q == ST_DONE);

    unified_mem_array #(
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .wr_en(mem_we),
        .waddr(acc_addr),
        .wdata(acc_wdata),
        .rd_en(mem_re),
        .raddr(acc_addr),
        .rdata(rdata)
    );

`ifdef UNIFIED_MEM_STALL_CNT_EN
    logic [31:0] stall_d, stall_q;

    // Count BUSY cycles, saturating at all ones.
    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_BUSY && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_unified_mem.sv
// tb_unified_mem: scoreboard bench for unified_mem. A LATENCY=4 instance gets
// directed and randomized traffic; a LATENCY=1 instance checks back-to-back
// spacing. Expected responses come from an associative-array memory model.
module tb_unified_mem;

    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        re, we;
    logic [13:0] addr;
    logic [63:0] wdata, rdata;
    logic        rdy;
    logic        re1, we1;
    logic [13:0] addr1;
    logic [63:0] wdata1, rdata1;
    logic        rdy1;
`ifdef UNIFIED_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt, stall_cnt1;
`endif

    unified_mem #(.ADDR_W(14), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdy(rdy)
`ifdef UNIFIED_MEM_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    unified_mem #(.ADDR_W(14), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst), .re(re1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .rdy(rdy1)
`ifdef UNIFIED_MEM_STALL_CNT_EN
        , .stall_cnt(stall_cnt1)
`endif
    );

    typedef struct {
        bit          is_read;
        logic [63:0] data;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp1_q[$];
    logic [63:0] model[int];
    logic [63:0] last_rd  = '0;
    logic [63:0] last_rd1 = '0;
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int          pool[8]  = '{16, 32, 5, 100, 1000, 16383, 0, 7};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor for the LATENCY=4 instance.
    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdy_without_request actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rdy_cycle", 64'(cyc), 64'(e.due));
                check(e.is_read ? "read_data" : "write_keeps_rdata", rdata, e.data);
            end
        end
    end

    // Monitor for the LATENCY=1 instance.
    always @(negedge clk) begin
        if (rdy1 === 1'b1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdy1_without_request actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp1_q.pop_front();
                check("l1_rdy_cycle", 64'(cyc), 64'(e.due));
                check("l1_rdata", rdata1, e.data);
            end
        end
    end

    // op: 0 read, 1 write, 2 read+write (treated as write).
    task automatic do_op(input int op, input logic [13:0] a, input logic [63:0] d,
                         input bit scramble, input logic [13:0] alt);
        exp_t e;
        bit   wr;
        @(negedge clk);
        wr    = (op != 0);
        re    = (op == 0 || op == 2);
        we    = wr;
        addr  = a;
        wdata = d;
        e.is_read = !wr;
        e.due     = cyc + LAT;
        if (wr) begin
            model[int'(a)] = d;
            e.data = last_rd;
        end else begin
            e.data  = model[int'(a)];
            last_rd = model[int'(a)];
        end
        exp_q.push_back(e);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy === 1'b1) return;
            if (scramble) begin
                addr  = alt;
                wdata = {$urandom, $urandom};
                re    = 1'($urandom_range(0, 1));
                we    = 1'($urandom_range(0, 1));
            end
        end
        checks++;
        failures++;
        $display("FAIL rdy_timeout actual=no_rdy expected=rdy within 40 cycles");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            re = 1'b0;
            we = 1'b0;
        end
    endtask

    initial begin
        int unsigned s;
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        re1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        check("reset_rdy", {63'b0, rdy}, 64'h0);
        check("reset_rdata", rdata, 64'h0);
        check("reset_rdy1", {63'b0, rdy1}, 64'h0);
        rst = 1'b0;

        // Write then read the same line; write leaves rdata at 0.
        do_op(1, 14'h0010, 64'h1111_2222_3333_4444, 1'b0, '0);
        do_op(0, 14'h0010, '0, 1'b0, '0);
`ifdef UNIFIED_MEM_STALL_CNT_EN
        check("stall_cnt_two_accesses", {32'b0, stall_cnt}, 64'd6);
`endif
        idle(3);
        check("rdata_hold", rdata, 64'h1111_2222_3333_4444);

        // Give every pool line a known value.
        for (int i = 1; i < 8; i++) begin
            do_op(1, 14'(pool[i]), {$urandom, $urandom}, 1'b0, '0);
        end

        // Inputs change mid-access: result must come from the latched line.
        do_op(0, 14'h0010, '0, 1'b1, 14'h0020);

        // Reset in cycle 2 of a write aborts it.
        @(negedge clk);
        we = 1'b1; re = 1'b0; addr = 14'h0005; wdata = 64'hDEAD;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rdy", {63'b0, rdy}, 64'h0);
        check("abort_rdata_cleared", rdata, 64'h0);
        last_rd  = '0;
        last_rd1 = '0;
`ifdef UNIFIED_MEM_STALL_CNT_EN
        check("abort_stall_cnt", {32'b0, stall_cnt}, 64'd0);
`endif
        idle(6);
        do_op(0, 14'h0005, '0, 1'b0, '0);

        // Randomized traffic over the pool.
        for (int i = 0; i < 30; i++) begin
            do_op($urandom_range(0, 2), 14'(pool[$urandom_range(0, 7)]), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 14'($urandom));
            idle($urandom_range(0, 2));
        end
        idle(1);

        // LATENCY=1: one write, then reads held continuously.
        @(negedge clk);
        we1 = 1'b1; addr1 = 14'h0003; wdata1 = 64'h0123_4567_89AB_CDEF;
        exp1_q.push_back('{is_read: 1'b0, data: last_rd1, due: cyc + 1});
        @(negedge clk);
        we1 = 1'b0; re1 = 1'b1;
        s = cyc + 1;
        exp1_q.push_back('{is_read: 1'b1, data: 64'h0123_4567_89AB_CDEF, due: s + 1});
        exp1_q.push_back('{is_read: 1'b1, data: 64'h0123_4567_89AB_CDEF, due: s + 3});
        exp1_q.push_back('{is_read: 1'b1, data: 64'h0123_4567_89AB_CDEF, due: s + 5});
        repeat (6) @(negedge clk);
        re1 = 1'b0;

        for (int n = 0; n < 100 && (exp_q.size() + exp1_q.size()) != 0; n++) @(negedge clk);
        idle(4);
        check("queues_drained", 64'(exp_q.size() + exp1_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
